// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: load/store mode encodings, writeback
// source codes, FSM states and the access-size helpers used to build bus requests.
package pipeline_defs;

    localparam logic [2:0] MSM_WORD   = 3'd0;
    localparam logic [2:0] MSM_HALF   = 3'd1;
    localparam logic [2:0] MSM_BYTE   = 3'd2;

    localparam logic [2:0] MSL_WORD   = 3'd0;
    localparam logic [2:0] MSL_HALF_S = 3'd1;
    localparam logic [2:0] MSL_HALF_U = 3'd2;
    localparam logic [2:0] MSL_BYTE_S = 3'd3;
    localparam logic [2:0] MSL_BYTE_U = 3'd4;

    localparam logic [2:0] SEL_LOAD   = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // A store wins when both request bits are set, so its mode decides the size.
    function automatic size_e access_size(input logic is_store,
                                          input logic [2:0] msm,
                                          input logic [2:0] msl);
        size_e sz;
        if (is_store) begin
            case (msm)
                MSM_HALF: sz = SZ_HALF;
                MSM_BYTE: sz = SZ_BYTE;
                default:  sz = SZ_WORD;
            endcase
        end else begin
            case (msl)
                MSL_HALF_S, MSL_HALF_U: sz = SZ_HALF;
                MSL_BYTE_S, MSL_BYTE_U: sz = SZ_BYTE;
                default:                sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr_lo);
        logic bad;
        case (sz)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input size_e sz,
                                               input logic [1:0] addr_lo,
                                               input logic mshw,
                                               input logic lshw);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be & {mshw, mshw, lshw, lshw};
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] data);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: moves the addressed byte/halfword lane down to bit 0 and
// sign- or zero-extends it according to the load mode.
module load_align
    import pipeline_defs::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  msl_i,
    output logic [31:0] data_o
);

    logic [31:0] lane_s;

    // Lane select and extension.
    always_comb begin
        lane_s = rdata_i >> {addr_i, 3'b000};
        case (msl_i)
            MSL_HALF_S: data_o = {{16{lane_s[15]}}, lane_s[15:0]};
            MSL_HALF_U: data_o = {16'h0000, lane_s[15:0]};
            MSL_BYTE_S: data_o = {{24{lane_s[7]}}, lane_s[7:0]};
            MSL_BYTE_U: data_o = {24'h000000, lane_s[7:0]};
            default:    data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores to the data-memory controller, stalls the
// pipeline while an access is outstanding and produces writeback/forward bundles.
module mem_access
    import pipeline_defs::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        ex_mem_msm,
    input  logic [2:0]        ex_mem_msl,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic              ex_mem_mshw,
    input  logic              ex_mem_lshw,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic [2:0]        ex_mem_selwsource,
    input  logic [4:0]        ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [DATA_W-1:0] ex_mem_aluout,
    input  logic [DATA_W-1:0] ex_mem_wbvalue,
    output logic              mem_mc_req,
    output logic              mem_mc_we,
    output logic [DATA_W-1:0] mem_mc_addr,
    output logic [3:0]        mem_mc_be,
    output logic [DATA_W-1:0] mem_mc_wdata,
    input  logic [DATA_W-1:0] mc_mem_rdata,
    input  logic              mc_mem_ready,
    output logic              mem_stall,
    output logic              mem_addrerr,
    output logic [DATA_W-1:0] mem_fw_wbvalue,
    output logic              mem_fw_writereg,
    output logic [4:0]        mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic [DATA_W-1:0] mem_wb_wbvalue
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               abort_q, abort_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mc_req_q, mc_req_d;
    logic               mc_we_q, mc_we_d;
    logic [31:0]        mc_addr_q, mc_addr_d;
    logic [3:0]         mc_be_q, mc_be_d;
    logic [31:0]        mc_wdata_q, mc_wdata_d;
    logic               addrerr_q, addrerr_d;
    logic [4:0]         wb_regdest_q, wb_regdest_d;
    logic               wb_writereg_q, wb_writereg_d;
    logic [31:0]        wb_wbvalue_q, wb_wbvalue_d;

    logic               mem_op_s;
    logic               is_store_s;
    size_e              size_s;
    logic               misalign_s;
    logic               issue_s;
    logic               timeout_s;
    logic               pass_wr_s;
    logic               done_wr_s;
    logic [31:0]        load_data_s;
    logic [31:0]        wb_value_s;
    logic               stall_s;
    logic               fw_writereg_s;
    logic [31:0]        fw_wbvalue_s;

    // Request decode; abort_q marks the held op of an aborted access so it is not re-issued.
    always_comb begin
        mem_op_s   = ex_mem_readmem | ex_mem_writemem;
        is_store_s = ex_mem_writemem;
        size_s     = access_size(is_store_s, ex_mem_msm, ex_mem_msl);
        misalign_s = is_misaligned(size_s, ex_mem_aluout[1:0]);
        issue_s    = (state_q == ST_IDLE) & mem_op_s & ~misalign_s & ~abort_q;
        timeout_s  = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
        pass_wr_s  = ex_mem_writereg & ~mem_op_s & ~abort_q;
        done_wr_s  = ex_mem_writereg & ~is_store_s;
        wb_value_s = (ex_mem_selwsource == SEL_LOAD) ? load_data_s : ex_mem_wbvalue;
    end

    load_align u_load_align (
        .rdata_i (rdata_q),
        .addr_i  (ex_mem_aluout[1:0]),
        .msl_i   (ex_mem_msl),
        .data_o  (load_data_s)
    );

    // FSM state register.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (mc_mem_ready) begin
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: controller drive, writeback capture, stall and forward values.
    always_comb begin
        mc_req_d      = 1'b0;
        mc_we_d       = mc_we_q;
        mc_addr_d     = mc_addr_q;
        mc_be_d       = mc_be_q;
        mc_wdata_d    = mc_wdata_q;
        rdata_d       = rdata_q;
        wait_cnt_d    = wait_cnt_q;
        abort_d       = abort_q;
        addrerr_d     = 1'b0;
        wb_regdest_d  = wb_regdest_q;
        wb_writereg_d = wb_writereg_q;
        wb_wbvalue_d  = wb_wbvalue_q;
        stall_s       = 1'b0;
        fw_writereg_s = 1'b0;
        fw_wbvalue_s  = wb_value_s;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                abort_d    = 1'b0;
                if (issue_s) begin
                    mc_req_d      = 1'b1;
                    mc_we_d       = is_store_s;
                    mc_addr_d     = {ex_mem_aluout[31:2], 2'b00};
                    mc_be_d       = byte_enable(size_s, ex_mem_aluout[1:0], ex_mem_mshw, ex_mem_lshw);
                    mc_wdata_d    = store_data(size_s, ex_mem_regb);
                    wb_writereg_d = 1'b0;
                    stall_s       = 1'b1;
                end else begin
                    wb_regdest_d  = ex_mem_regdest;
                    wb_writereg_d = pass_wr_s;
                    wb_wbvalue_d  = wb_value_s;
                    addrerr_d     = mem_op_s & misalign_s & ~abort_q;
                    fw_writereg_s = pass_wr_s;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mc_mem_ready) begin
                    rdata_d    = mc_mem_rdata;
                    mc_we_d    = 1'b0;
                    mc_addr_d  = 32'h0000_0000;
                    mc_be_d    = 4'b0000;
                    mc_wdata_d = 32'h0000_0000;
                end else if (timeout_s) begin
                    mc_we_d    = 1'b0;
                    mc_addr_d  = 32'h0000_0000;
                    mc_be_d    = 4'b0000;
                    mc_wdata_d = 32'h0000_0000;
                    addrerr_d  = 1'b1;
                    abort_d    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                wb_regdest_d  = ex_mem_regdest;
                wb_writereg_d = done_wr_s;
                wb_wbvalue_d  = wb_value_s;
                fw_writereg_s = done_wr_s;
            end
            default: begin
                mc_we_d    = 1'b0;
                mc_addr_d  = 32'h0000_0000;
                mc_be_d    = 4'b0000;
                mc_wdata_d = 32'h0000_0000;
                abort_d    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            abort_q       <= 1'b0;
            rdata_q       <= 32'h0000_0000;
            mc_req_q      <= 1'b0;
            mc_we_q       <= 1'b0;
            mc_addr_q     <= 32'h0000_0000;
            mc_be_q       <= 4'b0000;
            mc_wdata_q    <= 32'h0000_0000;
            addrerr_q     <= 1'b0;
            wb_regdest_q  <= 5'd0;
            wb_writereg_q <= 1'b0;
            wb_wbvalue_q  <= 32'h0000_0000;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            abort_q       <= abort_d;
            rdata_q       <= rdata_d;
            mc_req_q      <= mc_req_d;
            mc_we_q       <= mc_we_d;
            mc_addr_q     <= mc_addr_d;
            mc_be_q       <= mc_be_d;
            mc_wdata_q    <= mc_wdata_d;
            addrerr_q     <= addrerr_d;
            wb_regdest_q  <= wb_regdest_d;
            wb_writereg_q <= wb_writereg_d;
            wb_wbvalue_q  <= wb_wbvalue_d;
        end
    end

    assign mem_mc_req      = mc_req_q;
    assign mem_mc_we       = mc_we_q;
    assign mem_mc_addr     = mc_addr_q;
    assign mem_mc_be       = mc_be_q;
    assign mem_mc_wdata    = mc_wdata_q;
    assign mem_addrerr     = addrerr_q;
    assign mem_stall       = stall_s;
    assign mem_fw_writereg = fw_writereg_s;
    assign mem_fw_wbvalue  = fw_wbvalue_s;
    assign mem_wb_regdest  = wb_regdest_q;
    assign mem_wb_writereg = wb_writereg_q;
    assign mem_wb_wbvalue  = wb_wbvalue_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table-driven single-cycle ops, scripted memory accesses
// with a modelled controller, timeout abort and reset during an access.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  ex_mem_msm, ex_mem_msl, ex_mem_selwsource;
    logic        ex_mem_readmem, ex_mem_writemem, ex_mem_mshw, ex_mem_lshw, ex_mem_writereg;
    logic [31:0] ex_mem_regb, ex_mem_aluout, ex_mem_wbvalue;
    logic [4:0]  ex_mem_regdest;
    logic        mem_mc_req, mem_mc_we;
    logic [31:0] mem_mc_addr, mem_mc_wdata;
    logic [3:0]  mem_mc_be;
    logic [31:0] mc_mem_rdata;
    logic        mc_mem_ready;
    logic        mem_stall, mem_addrerr, mem_fw_writereg, mem_wb_writereg;
    logic [31:0] mem_fw_wbvalue, mem_wb_wbvalue;
    logic [4:0]  mem_wb_regdest;

    always #5 clock = ~clock;

    mem_access #(.DATA_W(32), .TIMEOUT(255)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_msm(ex_mem_msm), .ex_mem_msl(ex_mem_msl),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_mshw(ex_mem_mshw), .ex_mem_lshw(ex_mem_lshw),
        .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
        .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_aluout(ex_mem_aluout), .ex_mem_wbvalue(ex_mem_wbvalue),
        .mem_mc_req(mem_mc_req), .mem_mc_we(mem_mc_we), .mem_mc_addr(mem_mc_addr),
        .mem_mc_be(mem_mc_be), .mem_mc_wdata(mem_mc_wdata),
        .mc_mem_rdata(mc_mem_rdata), .mc_mem_ready(mc_mem_ready),
        .mem_stall(mem_stall), .mem_addrerr(mem_addrerr),
        .mem_fw_wbvalue(mem_fw_wbvalue), .mem_fw_writereg(mem_fw_writereg),
        .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
        .mem_wb_wbvalue(mem_wb_wbvalue)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic        err;
        logic        chk;
    } wb_exp_t;
    wb_exp_t exp_q[$];

    typedef struct packed {
        logic        rdm;
        logic        wrm;
        logic [2:0]  msm;
        logic [2:0]  msl;
        logic [31:0] addr;
        logic [2:0]  selw;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic        e_wr;
        logic        e_err;
        logic        e_chk;
    } vec_t;
    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_idle();
        ex_mem_readmem = 1'b0; ex_mem_writemem = 1'b0;
        ex_mem_msm = 3'd0; ex_mem_msl = 3'd0; ex_mem_mshw = 1'b1; ex_mem_lshw = 1'b1;
        ex_mem_regb = 32'h0; ex_mem_selwsource = 3'd0; ex_mem_regdest = 5'd0;
        ex_mem_writereg = 1'b0; ex_mem_aluout = 32'h0; ex_mem_wbvalue = 32'h0;
        mc_mem_ready = 1'b0; mc_mem_rdata = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, ".req"},      32'(mem_mc_req),      32'h0);
        check32({tag, ".we"},       32'(mem_mc_we),       32'h0);
        check32({tag, ".addr"},     mem_mc_addr,          32'h0);
        check32({tag, ".be"},       32'(mem_mc_be),       32'h0);
        check32({tag, ".wdata"},    mem_mc_wdata,         32'h0);
        check32({tag, ".stall"},    32'(mem_stall),       32'h0);
        check32({tag, ".addrerr"},  32'(mem_addrerr),     32'h0);
        check32({tag, ".wb_rd"},    32'(mem_wb_regdest),  32'h0);
        check32({tag, ".wb_wr"},    32'(mem_wb_writereg), 32'h0);
        check32({tag, ".wb_val"},   mem_wb_wbvalue,       32'h0);
        check32({tag, ".fw_wr"},    32'(mem_fw_writereg), 32'h0);
    endtask

    task automatic pop_check(input string tag);
        wb_exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got wb %h expected an entry", tag, mem_wb_wbvalue);
            return;
        end
        n_checks--;
        e = exp_q.pop_front();
        check32({tag, ".wb_rd"},   32'(mem_wb_regdest),  32'(e.rd));
        check32({tag, ".wb_wr"},   32'(mem_wb_writereg), 32'(e.wr));
        check32({tag, ".addrerr"}, 32'(mem_addrerr),     32'(e.err));
        if (e.chk) check32({tag, ".wb_val"}, mem_wb_wbvalue, e.val);
    endtask

    // Drives one memory access, plays the controller, and checks bus, stall and writeback.
    task automatic mem_op(input string name,
                          input logic rdm, input logic wrm, input logic [2:0] msm_v, input logic [2:0] msl_v,
                          input logic [31:0] addr_v, input logic [31:0] regb_v,
                          input logic mshw_v, input logic lshw_v, input logic [2:0] selw_v,
                          input logic [4:0] rd_v, input logic wr_v,
                          input int ready_delay, input logic [31:0] rdata_v,
                          input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic e_wr, input logic [31:0] e_val, input logic chk_val,
                          input logic e_err, input int e_stall);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int waits     = -1;
        bit done      = 0;
        bit hold_ok   = 1;
        @(negedge clock); #1;
        set_idle();
        ex_mem_readmem = rdm; ex_mem_writemem = wrm; ex_mem_msm = msm_v; ex_mem_msl = msl_v;
        ex_mem_aluout = addr_v; ex_mem_regb = regb_v; ex_mem_mshw = mshw_v; ex_mem_lshw = lshw_v;
        ex_mem_selwsource = selw_v; ex_mem_regdest = rd_v; ex_mem_writereg = wr_v;
        ex_mem_wbvalue = 32'h0BAD_0BAD;
        exp_q.push_back('{rd_v, e_wr, e_val, 1'b0, chk_val});
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(posedge clock);
            if (mem_stall) stall_cnt++;
            if (mem_mc_req) begin
                req_cnt++;
                waits = 0;
                check32({name, ".we"},    32'(mem_mc_we), 32'(e_we));
                check32({name, ".be"},    32'(mem_mc_be), 32'(e_be));
                check32({name, ".wdata"}, mem_mc_wdata,   e_wdata);
                check32({name, ".addr"},  mem_mc_addr,    {addr_v[31:2], 2'b00});
            end else if (mem_stall && waits > 0) begin
                if (mem_mc_be !== e_be || mem_mc_we !== e_we || mem_mc_wdata !== e_wdata ||
                    mem_mc_addr !== {addr_v[31:2], 2'b00}) hold_ok = 0;
            end
            if (!mem_stall) begin
                done = 1;
                check32({name, ".addrerr"}, 32'(mem_addrerr),     32'(e_err));
                check32({name, ".fw_wr"},   32'(mem_fw_writereg), 32'(e_wr));
                if (chk_val) check32({name, ".fw_val"}, mem_fw_wbvalue, e_val);
            end else begin
                @(negedge clock); #1;
                if (waits >= 0) begin
                    waits++;
                    mc_mem_ready = (ready_delay >= 0) && (waits == ready_delay + 1);
                    mc_mem_rdata = mc_mem_ready ? rdata_v : 32'h0;
                end
            end
        end
        check32({name, ".completed"}, 32'(done), 32'h1);
        check32({name, ".stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
        check32({name, ".req_cycles"}, 32'(req_cnt), 32'h1);
        check32({name, ".bus_held"}, 32'(hold_ok), 32'h1);
        @(negedge clock); #1;
        set_idle();
        @(posedge clock);
        pop_check(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rdm   wrm   msm   msl   addr          selw  rd     wr    val           e_wr  e_err e_chk
        vecs[0] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 3'd0, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0010, 3'd2, 5'd31, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 3'd0, 5'd3,  1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0101, 3'd1, 5'd9,  1'b1, 32'h0000_5555, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 3'd1, 3'd0, 32'h0000_0203, 3'd0, 5'd4,  1'b0, 32'h0000_7777, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 3'd2, 32'h0000_0301, 3'd1, 5'd11, 1'b1, 32'h0000_6666, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 3'd0, 5'd0,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 3'd7, 5'd17, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};

        reset = 1'b0;
        set_idle();
        repeat (2) @(posedge clock);
        check_all_zero("reset");
        @(negedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clock); #1;
            set_idle();
            ex_mem_readmem = vecs[i].rdm; ex_mem_writemem = vecs[i].wrm;
            ex_mem_msm = vecs[i].msm; ex_mem_msl = vecs[i].msl; ex_mem_aluout = vecs[i].addr;
            ex_mem_selwsource = vecs[i].selw; ex_mem_regdest = vecs[i].rd;
            ex_mem_writereg = vecs[i].wr; ex_mem_wbvalue = vecs[i].val;
            exp_q.push_back('{vecs[i].rd, vecs[i].e_wr, vecs[i].val, vecs[i].e_err, vecs[i].e_chk});
            @(posedge clock);
            check32($sformatf("vec%0d.stall", i), 32'(mem_stall),       32'h0);
            check32($sformatf("vec%0d.req", i),   32'(mem_mc_req),      32'h0);
            check32($sformatf("vec%0d.fw_wr", i), 32'(mem_fw_writereg), 32'(vecs[i].e_wr));
            if (vecs[i].e_chk) check32($sformatf("vec%0d.fw_val", i), mem_fw_wbvalue, vecs[i].val);
            if (i > 0) pop_check($sformatf("vec%0d", i - 1));
        end
        @(negedge clock); #1;
        set_idle();
        @(posedge clock);
        pop_check("vec7");

        //      name        rdm   wrm   msm   msl   addr          regb          mshw  lshw  selw  rd    wr    dly rdata          we    be       wdata          e_wr  e_val          chk   err   stall
        mem_op("lb_signed", 1'b1, 1'b0, 3'd0, 3'd3, 32'h0000_0103, 32'h0,        1'b1, 1'b1, 3'd1, 5'd7, 1'b1, 2,  32'h80FF_FF7F, 1'b0, 4'b1000, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 5);
        mem_op("sh",        1'b0, 1'b1, 3'd1, 3'd0, 32'h0000_0202, 32'hAAAA_BEEF, 1'b1, 1'b1, 3'd0, 5'd4, 1'b1, 0,  32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 3);
        mem_op("sw_lomask", 1'b0, 1'b1, 3'd0, 3'd0, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1, 3'd0, 5'd2, 1'b0, 1,  32'h0,         1'b1, 4'b0011, 32'h1234_5678, 1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 4);
        mem_op("lhu",       1'b1, 1'b0, 3'd0, 3'd2, 32'h0000_0012, 32'h0,        1'b1, 1'b1, 3'd1, 5'd12,1'b1, 0,  32'h8001_1234, 1'b0, 4'b1100, 32'h0,         1'b1, 32'h0000_8001, 1'b1, 1'b0, 3);
        mem_op("rw_is_sb",  1'b1, 1'b1, 3'd2, 3'd0, 32'h0000_0007, 32'h0000_00A5, 1'b1, 1'b1, 3'd0, 5'd6, 1'b1, 0,  32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 3);

        // Reset asserted while the access sits in WAIT.
        @(negedge clock); #1;
        set_idle();
        ex_mem_readmem = 1'b1; ex_mem_aluout = 32'h0000_0044; ex_mem_regdest = 5'd10;
        ex_mem_writereg = 1'b1; ex_mem_selwsource = 3'd1;
        @(posedge clock);
        @(posedge clock);
        check32("rst_wait.req_seen", 32'(mem_mc_req), 32'h1);
        @(posedge clock);
        check32("rst_wait.in_wait", 32'(mem_stall), 32'h1);
        @(negedge clock); #1;
        reset = 1'b0;
        set_idle();
        @(posedge clock);
        check_all_zero("rst_wait");
        @(negedge clock); #1;
        reset = 1'b1;

        mem_op("lbu_after", 1'b1, 1'b0, 3'd0, 3'd4, 32'h0000_0021, 32'h0,        1'b1, 1'b1, 3'd1, 5'd13,1'b1, 1,  32'h1122_C344, 1'b0, 4'b0010, 32'h0,         1'b1, 32'h0000_00C3, 1'b1, 1'b0, 4);
        mem_op("timeout",   1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0080, 32'h0,        1'b1, 1'b1, 3'd1, 5'd8, 1'b1, -1, 32'h0,         1'b0, 4'b1111, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 257);

        @(posedge clock);
        check32("post_timeout.addrerr", 32'(mem_addrerr), 32'h0);
        check32("post_timeout.stall",   32'(mem_stall),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
